// File: rtl/arb_mux_pkg.sv
// Shared encodings for the N-channel arbitrating mux: selection policies and output-stage states.
package arb_mux_pkg;

  localparam logic [1:0] MODE_FIXED  = 2'b00;
  localparam logic [1:0] MODE_RR     = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/arb_mux_n_grant.sv
// Combinational one-hot grant (fixed / round-robin / manual) plus the round-robin pointer.
// Pointer advances past the served channel only on a round-robin transfer.
module arb_grant
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode_i,
  input  logic [SELW-1:0] sel_i,
  input  logic [NCH-1:0]  valid_i,
  input  logic            xfer_i,
  output logic [NCH-1:0]  grant_o,
  output logic [SELW-1:0] idx_o,
  output logic            any_o
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic            found;
  logic [SELW-1:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    case (mode_i)
      MODE_RR: begin
        // First pass covers ptr..NCH-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NCH; i++) begin
          if (!found && valid_i[i] && (SELW'(i) >= ptr_q)) begin
            found = 1'b1;
            idx   = SELW'(i);
          end
        end
        for (int i = 0; i < NCH; i++) begin
          if (!found && valid_i[i]) begin
            found = 1'b1;
            idx   = SELW'(i);
          end
        end
      end
      MODE_MANUAL: begin
        for (int i = 0; i < NCH; i++) begin
          if (SELW'(i) == sel_i && valid_i[i]) begin
            found = 1'b1;
            idx   = SELW'(i);
          end
        end
      end
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (!found && valid_i[i]) begin
            found = 1'b1;
            idx   = SELW'(i);
          end
        end
      end
    endcase
  end

  always_comb begin
    grant_o      = '0;
    grant_o[idx] = found;
  end

  assign idx_o = idx;
  assign any_o = found;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_i && mode_i == MODE_RR) begin
      ptr_d = (int'(idx) == NCH - 1) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating mux into a single-entry output register; 1 cycle accept-to-out_valid.
// in_ready drops while the held word is stalled; drain and reload in one cycle keeps full rate.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [SELW-1:0]  sel_in,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic [0:0]      state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;

  logic [NCH-1:0]  grant;
  logic [SELW-1:0] grant_idx;
  logic            grant_any;
  logic            load_en;
  logic            xfer;
  logic [W-1:0]    mux_dat;

  arb_grant #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_i  (mode),
    .sel_i   (sel_in),
    .valid_i (in_valid),
    .xfer_i  (xfer),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // out_ready reaches in_ready only through load_en, never the grant choice.
  assign load_en  = (state_q == ST_EMPTY) | out_ready;
  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign xfer     = rst_n & load_en & grant_any;

  always_comb begin
    mux_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        mux_dat = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = mux_dat;
      sel_d   = grant_idx;
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a stateful vector table on a 4x8 instance, then
// hand sequences for async reset, and 5x16 / 2x1 instances for wrap and mode 11.
module tb_arb_mux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NCH=4, W=8
  logic [1:0]  mode4 = 2'b00;
  logic [1:0]  sel4 = 2'd0;
  logic [3:0]  iv4 = 4'b0000;
  logic [31:0] dat4;
  logic [3:0]  ir4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;
  logic        ordy4 = 1'b0;

  // NCH=5, W=16
  logic [1:0]  mode5 = 2'b00;
  logic [2:0]  sel5 = 3'd0;
  logic [4:0]  iv5 = 5'b00000;
  logic [79:0] dat5;
  logic [4:0]  ir5;
  logic        ov5;
  logic [15:0] od5;
  logic [2:0]  os5;
  logic        ordy5 = 1'b0;

  // NCH=2, W=1
  logic [1:0]  mode2 = 2'b00;
  logic [0:0]  sel2 = 1'b0;
  logic [1:0]  iv2 = 2'b00;
  logic [1:0]  dat2 = 2'b01;
  logic [1:0]  ir2;
  logic        ov2;
  logic [0:0]  od2;
  logic [0:0]  os2;
  logic        ordy2 = 1'b0;

  assign dat4 = {8'hC3, 8'h5C, 8'hA1, 8'h10};
  assign dat5 = {16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};

  arb_mux_n #(.NCH(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel_in(sel4), .in_valid(iv4),
    .in_data(dat4), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
    .out_sel(os4), .out_ready(ordy4)
  );

  arb_mux_n #(.NCH(5), .W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel_in(sel5), .in_valid(iv5),
    .in_data(dat5), .in_ready(ir5), .out_valid(ov5), .out_data(od5),
    .out_sel(os5), .out_ready(ordy5)
  );

  arb_mux_n #(.NCH(2), .W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2), .sel_in(sel2), .in_valid(iv2),
    .in_data(dat2), .in_ready(ir2), .out_valid(ov2), .out_data(od2),
    .out_sel(os2), .out_ready(ordy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_os;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // Each row depends on state left by the previous one (ptr, output register).
    tbl[0]  = '{2'b00, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[1]  = '{2'b00, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[2]  = '{2'b00, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
    tbl[3]  = '{2'b00, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC3, 2'd3};
    tbl[4]  = '{2'b10, 2'd2, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h5C, 2'd2};
    tbl[5]  = '{2'b10, 2'd2, 4'b1011, 1'b0, 4'b0000, 1'b1, 8'h5C, 2'd2};
    tbl[6]  = '{2'b10, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 8'h5C, 2'd2};
    tbl[7]  = '{2'b11, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[8]  = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[9]  = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[10] = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h5C, 2'd2};
    tbl[11] = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
    tbl[12] = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[13] = '{2'b01, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    tbl[14] = '{2'b01, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    tbl[15] = '{2'b01, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
    tbl[16] = '{2'b01, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[17] = '{2'b01, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[18] = '{2'b01, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'hC3, 2'd3};
    tbl[19] = '{2'b01, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hC3, 2'd3};

    // Reset state, with requests pending so in_ready gating is exercised.
    iv4 = 4'b1111;
    repeat (2) step();
    chk("rst_in_ready", 32'(ir4), 32'h0);
    chk("rst_out_valid", 32'(ov4), 32'h0);
    chk("rst_out_data", 32'(od4), 32'h0);
    chk("rst_out_sel", 32'(os4), 32'h0);
    iv4 = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      mode4 = tbl[i].mode;
      sel4  = tbl[i].sel;
      iv4   = tbl[i].iv;
      ordy4 = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(ir4), 32'(tbl[i].e_ir));
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(ov4), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(od4), 32'(tbl[i].e_od));
      chk($sformatf("v%0d_out_sel", i), 32'(os4), 32'(tbl[i].e_os));
    end

    // Mid-stream reset: load ch0 in RR (ptr -> 1), then reset asynchronously.
    mode4 = 2'b01; iv4 = 4'b1111; ordy4 = 1'b0;
    step();
    chk("pre_rst_out_valid", 32'(ov4), 32'h1);
    chk("pre_rst_out_data", 32'(od4), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(ov4), 32'h0);
    chk("async_rst_out_data", 32'(od4), 32'h0);
    chk("async_rst_out_sel", 32'(os4), 32'h0);
    chk("async_rst_in_ready", 32'(ir4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy4 = 1'b1;
    #1;
    chk("post_rst_rr_in_ready", 32'(ir4), 32'h1);
    step();
    chk("post_rst_rr_out_sel", 32'(os4), 32'h0);
    chk("post_rst_rr_out_valid", 32'(ov4), 32'h1);
    iv4 = 4'b0000;
    step();

    // NCH=5: round-robin wraps 4 -> 0 with continuous throughput.
    mode5 = 2'b01; iv5 = 5'b11111; ordy5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("n5_rr%0d_out_sel", k), 32'(os5), 32'(k % 5));
      chk($sformatf("n5_rr%0d_out_data", k), 32'(od5), 32'h0000B000 + 32'(k % 5));
      chk($sformatf("n5_rr%0d_out_valid", k), 32'(ov5), 32'h1);
    end
    mode5 = 2'b11; iv5 = 5'b11010;
    #1;
    chk("n5_mode11_in_ready", 32'(ir5), 32'h02);
    mode5 = 2'b00;
    #1;
    chk("n5_mode00_in_ready", 32'(ir5), 32'h02);
    mode5 = 2'b11;
    step();
    chk("n5_mode11_out_data", 32'(od5), 32'h0000B001);
    mode5 = 2'b10; sel5 = 3'd6; iv5 = 5'b11111;
    #1;
    chk("n5_manual_oob_in_ready", 32'(ir5), 32'h0);
    step();
    chk("n5_manual_oob_out_valid", 32'(ov5), 32'h0);
    sel5 = 3'd4;
    #1;
    chk("n5_manual4_in_ready", 32'(ir5), 32'h10);
    iv5 = 5'b00000;
    step();

    // NCH=2, W=1: round-robin alternation and mode 11 as fixed priority.
    mode2 = 2'b01; iv2 = 2'b11; ordy2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("n2_rr%0d_out_sel", k), 32'(os2), 32'(k % 2));
      chk($sformatf("n2_rr%0d_out_data", k), 32'(od2), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    mode2 = 2'b11;
    #1;
    chk("n2_mode11_in_ready", 32'(ir2), 32'h1);
    iv2 = 2'b10;
    #1;
    chk("n2_mode11_ch1_in_ready", 32'(ir2), 32'h2);
    step();
    chk("n2_mode11_out_sel", 32'(os2), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
